output_argmax_reader: RTL and testbench
=======================================

// Module: output_argmax_reader
// PURPOSE
// Reader side of the output-unit score RAM. On start, sequentially reads entries
// 0..NUM_OUTPUTS-1 through the RAM's registered-address read port, compares
// them as signed scores, and reports the index of the largest (the classified digit)
// and its score. Sits between the output-layer RAM and the result/display logic.
// PARAMETERS
// DATA_WIDTH   8   score width; two's-complement signed, matches MAC output
// ADDR_WIDTH   4   RAM address width (16 entries)
// NUM_OUTPUTS  10  entries scanned (indices 0..NUM_OUTPUTS-1); 1 <= N <= 2**ADDR_WIDTH
// PORTS
// clk       in   1           rising-edge clock, shared with the RAM
// rst_n     in   1           asynchronous, active-low reset
// start     in   1           begin a scan; sampled only in IDLE
// ram_q     in   DATA_WIDTH  RAM read data: contents at address registered last edge
// ram_addr  out  ADDR_WIDTH  RAM read address (registered output)
// busy      out  1           high from the cycle after start is accepted until done
// done      out  1           one-cycle pulse: digit/max_val just updated
// digit     out  ADDR_WIDTH  index of the maximum score from the last completed scan
// max_val   out  DATA_WIDTH  signed maximum score from the last completed scan
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; ram_addr=0, busy=0, done=0, digit=0,
//   max_val=0, internal running max/index/counters cleared.
// - The RAM latches ram_addr on an edge; ram_q shows that entry after the edge.
//   So data for address k is sampled one cycle after address k was driven.
// - FSM: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> SCAN, ram_addr<=0, busy<=1.
//   SCAN: ram_addr increments each edge up to NUM_OUTPUTS-1; from the second SCAN
//     edge on, the block samples ram_q for the address driven one cycle earlier.
//     After driving NUM_OUTPUTS-1 -> DRAIN.
//   DRAIN: samples ram_q for entry NUM_OUTPUTS-1; -> DONE.
//   DONE: digit/max_val <= running index/max, done=1 for exactly this cycle,
//     busy=0 -> IDLE.
// - Timing: ram_addr = k during cycle k+1 after E0. Entry k is sampled at the end
//   of cycle k+2. done is high during cycle NUM_OUTPUTS+2 (cycle 12 for N=10).
//   Next start is accepted at the following edge.
// - Compare: entry 0 loads the running max unconditionally. For entry k>0 the
//   running max is replaced only if $signed(ram_q) > running max (strict).
//   Ties therefore keep the lowest index.
// - ram_addr holds its last value (NUM_OUTPUTS-1) after a scan; it returns to 0
//   only on the next accepted start or on reset.
// - start while busy or in DONE is ignored; it is neither queued nor restarted.
// - digit/max_val change only in DONE. Mid-scan they hold the previous result.
// - rst_n asserted mid-scan: immediate return to reset values. No done pulse, and
//   the partial result is discarded.
// - NUM_OUTPUTS=1: scans entry 0 only; done in cycle 3; digit=0.
// TESTING
// 1 RAM[0..9]={5,-3,20,7,20,1,0,-8,19,2}, pulse start -> done once in cycle 12,
//   digit=2 (tie with idx 4 keeps lowest), max_val=20, busy high cycles 1-11.
// 2 RAM[0..8]=-128 (0x80), RAM[9]=-1 (0xFF) -> digit=9, max_val=-1.
//   Signed compare: 0x7F beats 0x80.
// 3 Address trace: ram_addr = 0,1,...,9 in cycles 1..10, then holds 9.
//   RAM[10..15]=0x7F never selected.
// 4 start held high for 30 cycles -> scans complete back-to-back,
//   done every 13 cycles, no overlap.
//   A start pulse mid-scan (cycle 5) does not alter timing or the result.
// 5 rst_n low in cycle 6 of a scan -> all outputs 0 asynchronously, no done.
//   A new start after release gives the correct result for the current RAM.
// 6 Write RAM between scans (RAM[3]=100) -> second scan reports digit=3,
//   max_val=100. digit/max_val hold the old values until the second done.

Source files
------------

// File: rtl/output_argmax_reader_if.sv
// Bus between the argmax reader and its surroundings: start request, RAM read
// port (address out, data in) and the classification result.
//   start     host -> reader  begin a scan (honoured only when idle)
//   ram_q     RAM  -> reader  data at the address registered on the last edge
//   ram_addr  reader -> RAM   registered read address
//   busy      reader -> host  scan in progress
//   done      reader -> host  one-cycle pulse, digit/max_val freshly updated
//   digit     reader -> host  index of the largest signed score
//   max_val   reader -> host  largest signed score
// The slave modport is the reader; master is the host/RAM side.
interface output_argmax_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) ();
   logic                  start;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] digit;
   logic [DATA_WIDTH-1:0] max_val;

   modport master (
      output start, ram_q,
      input  ram_addr, busy, done, digit, max_val
   );

   modport slave (
      input  start, ram_q,
      output ram_addr, busy, done, digit, max_val
   );
endinterface

// File: rtl/output_argmax_reader.sv
// Scans output-unit score RAM entries 0..NUM_OUTPUTS-1 through a registered-address
// read port and reports the index and value of the largest signed score.
// Ports:
//   clk    rising-edge clock, shared with the RAM
//   rst_n  asynchronous active-low reset
//   bus    output_argmax_reader_if.slave (start, ram_q in; ram_addr, busy, done,
//          digit, max_val out)
module output_argmax_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int NUM_OUTPUTS = 10
) (
   input logic                    clk,
   input logic                    rst_n,
   output_argmax_reader_if.slave  bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_OUTPUTS - 1);

   logic [1:0]                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
   logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
   logic [ADDR_WIDTH-1:0]        run_idx_q, run_idx_d;
   logic [ADDR_WIDTH-1:0]        digit_q, digit_d;
   logic [DATA_WIDTH-1:0]        max_val_q, max_val_d;

   logic                         sample;
   logic [ADDR_WIDTH-1:0]        sample_idx;

   // ram_q lags ram_addr by one cycle: in SCAN it holds entry addr-1 (nothing
   // valid yet while addr is still 0); in DRAIN it holds the last entry.
   always_comb begin
      sample     = 1'b0;
      sample_idx = addr_q;
      if (state_q == ST_SCAN && addr_q != '0) begin
         sample     = 1'b1;
         sample_idx = addr_q - 1'b1;
      end else if (state_q == ST_DRAIN) begin
         sample = 1'b1;
      end
   end

   // Entry 0 seeds the running max; later entries win only on strictly greater,
   // so ties keep the lowest index.
   always_comb begin
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      if (sample && (sample_idx == '0 || $signed(bus.ram_q) > run_max_q)) begin
         run_max_d = $signed(bus.ram_q);
         run_idx_d = sample_idx;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      digit_d   = digit_q;
      max_val_d = max_val_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_SCAN;
               addr_d  = '0;
            end
         end
         ST_SCAN: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Publish including the final sample so the result is valid with done.
            state_d   = ST_DONE;
            digit_d   = run_idx_d;
            max_val_d = run_max_d;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         digit_q   <= '0;
         max_val_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         digit_q   <= digit_d;
         max_val_q <= max_val_d;
      end
   end

   assign bus.ram_addr = addr_q;
   assign bus.busy     = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.digit    = digit_q;
   assign bus.max_val  = max_val_q;
endmodule

// File: tb/tb_output_argmax_reader.sv
// Scoreboard bench for output_argmax_reader with a registered-address RAM model.
module tb_output_argmax_reader;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   output_argmax_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   output_argmax_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_OUTPUTS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // RAM: address latched on the edge, data visible after it.
   logic [DW-1:0] mem [16];
   logic [AW-1:0] ram_addr_lat = '0;
   always @(posedge clk) ram_addr_lat <= bus.ram_addr;
   assign bus.ram_q = mem[ram_addr_lat];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            when;
      logic [AW-1:0] digit;
      logic [DW-1:0] maxv;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   bit            scan_on = 1'b0;
   int            acc = 0;
   logic [AW-1:0] cur_digit = '0;
   logic [DW-1:0] cur_max = '0;
   bit            mon_en = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: largest signed value first, then the lowest index holding it.
   task automatic ref_scan(output logic [AW-1:0] d, output logic [DW-1:0] m);
      int best;
      best = -1000;
      for (int i = 0; i < N; i++)
         if (int'($signed(mem[i])) > best) best = int'($signed(mem[i]));
      d = '0;
      for (int i = N - 1; i >= 0; i--)
         if (int'($signed(mem[i])) == best) d = AW'(i);
      m = DW'(best);
   endtask

   // Drive start for one cycle; if the reader is idle the model accepts the scan.
   task automatic step(input bit st);
      logic [AW-1:0] d;
      logic [DW-1:0] m;
      @(negedge clk);
      bus.start = st;
      if (st && (!scan_on || cyc >= acc + N + 3)) begin
         ref_scan(d, m);
         sb.push_back('{when: cyc + N + 2, digit: d, maxv: m});
         scan_on = 1'b1;
         acc     = cyc;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) step(1'b0);
      step(1'b0);
      check("drain_timeout", sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, int'(bus.ram_addr), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_digit"}, int'(bus.digit), 0);
      check({tag, "_max"}, int'(bus.max_val), 0);
   endtask

   // Monitor: compares every cycle against the model, pops on done.
   always @(negedge clk) begin
      exp_t e;
      int   ea;
      if (mon_en && rst_n) begin
         check("busy", int'(bus.busy),
               int'(scan_on && cyc >= acc + 1 && cyc <= acc + N + 1));
         if (!scan_on) begin
            check("ram_addr_idle", int'(bus.ram_addr), 0);
         end else if (cyc > acc) begin
            ea = cyc - acc - 1;
            if (ea > N - 1) ea = N - 1;
            check("ram_addr", int'(bus.ram_addr), ea);
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.when);
               check("digit", int'(bus.digit), int'(e.digit));
               check("max_val", int'($signed(bus.max_val)), int'($signed(e.maxv)));
               cur_digit = e.digit;
               cur_max   = e.maxv;
            end
         end else begin
            check("digit_hold", int'(bus.digit), int'(cur_digit));
            check("max_hold", int'(bus.max_val), int'(cur_max));
            if (sb.size() != 0 && sb[0].when <= cyc) begin
               check("missing_done", cyc, sb[0].when);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] t1 [10];
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Tie at 20 (idx 2 and 4); tail entries 0x7F lie outside the scan range.
      t1 = '{8'h05, 8'hFD, 8'h14, 8'h07, 8'h14, 8'h01, 8'h00, 8'hF8, 8'h13, 8'h02};
      for (int i = 0; i < 10; i++) mem[i] = t1[i];
      for (int i = 10; i < 16; i++) mem[i] = 8'h7F;
      step(1'b1);
      drain();
      check("t1_digit", int'(bus.digit), 2);
      check("t1_max", int'($signed(bus.max_val)), 20);
      check("t1_addr_hold", int'(bus.ram_addr), 9);

      // Signed compare: -1 beats -128.
      for (int i = 0; i < 9; i++) mem[i] = 8'h80;
      mem[9] = 8'hFF;
      step(1'b1);
      drain();
      check("t2_digit", int'(bus.digit), 9);
      check("t2_max", int'($signed(bus.max_val)), -1);

      // Start held high: back-to-back scans.
      repeat (30) step(1'b1);
      drain();
      // Start pulse mid-scan is ignored.
      step(1'b1);
      repeat (3) step(1'b0);
      step(1'b1);
      drain();

      // Reset in cycle 6 of a scan.
      step(1'b1);
      repeat (5) step(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      sb.delete();
      scan_on   = 1'b0;
      cur_digit = '0;
      cur_max   = '0;
      @(negedge clk);
      check_reset_outputs("midreset_hold");
      rst_n = 1'b1;
      repeat (2) step(1'b0);
      step(1'b1);
      drain();
      check("t5_digit", int'(bus.digit), 9);

      // RAM rewrite between scans.
      mem[3] = 8'h64;
      step(1'b1);
      drain();
      check("t6_digit", int'(bus.digit), 3);
      check("t6_max", int'($signed(bus.max_val)), 100);

      // Random contents and random start patterns.
      for (int s = 0; s < 25; s++) begin
         for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
         if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, N - 1)] = mem[$urandom_range(0, N - 1)];
         for (int c = 0; c < 20; c++) step($urandom_range(0, 3) == 0);
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
